// File: rtl/tensor_core_pkg.sv
// Shared types and constants for the tensor core result drain.
// Build option DRAIN_COLUMN_MAJOR_EN selects column-major drain order.
package tensor_core_pkg;

  localparam int ELEM_WIDTH = 4;
  localparam int MATRIX_DIM = 4;

  typedef logic signed [ELEM_WIDTH-1:0] elem_t;
  typedef elem_t matrix_t [MATRIX_DIM][MATRIX_DIM];

  typedef enum logic {
    IDLE,
    STREAM
  } drain_state_t;

  // Row coordinate of the element emitted at a given drain position.
  function automatic logic [1:0] index_row(input logic [3:0] index);
`ifdef DRAIN_COLUMN_MAJOR_EN
    return index[1:0];
`else
    return index[3:2];
`endif
  endfunction

  // Column coordinate of the element emitted at a given drain position.
  function automatic logic [1:0] index_col(input logic [3:0] index);
`ifdef DRAIN_COLUMN_MAJOR_EN
    return index[3:2];
`else
    return index[1:0];
`endif
  endfunction

endpackage

// File: rtl/done_edge_detect.sv
// Registered rising-edge detector. RESET_VALUE sets the remembered level
// after reset, so a level already high at reset release can be ignored.
module done_edge_detect #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic level_q;

  // Remember the previous level of the monitored flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= RESET_VALUE;
    end else begin
      level_q <= level;
    end
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/tensor_core_result_drain.sv
// Snapshots the 4x4 tensor core result on the rising edge of its done flag
// and streams the 16 signed elements over valid/ready with row/col tags.
// Build option DRAIN_COLUMN_MAJOR_EN switches the drain to column-major order.
module tensor_core_result_drain
  import tensor_core_pkg::*;
(
  input  logic                         clock_in,
  input  logic                         reset_in,
  input  logic                         is_done_with_calculation,
  input  logic signed [ELEM_WIDTH-1:0] tensor_core_output [MATRIX_DIM][MATRIX_DIM],
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [ELEM_WIDTH-1:0] out_data,
  output logic [1:0]                   out_row,
  output logic [1:0]                   out_col,
  output logic                         out_last,
  output logic                         drain_busy,
  output logic                         drain_complete,
  output logic                         overrun_error
);

  drain_state_t state;
  drain_state_t next_state;
  matrix_t      buffer;
  logic [3:0]   index;
  logic [1:0]   cur_row;
  logic [1:0]   cur_col;
  logic         capture;
  logic         handshake;
  logic         last_handshake;

  done_edge_detect #(
    .RESET_VALUE (1'b1)
  ) u_done_edge (
    .clk   (clock_in),
    .reset (reset_in),
    .level (is_done_with_calculation),
    .rise  (capture)
  );

  assign cur_row        = index_row(index);
  assign cur_col        = index_col(index);
  assign handshake      = (state == STREAM) & out_ready;
  assign last_handshake = handshake & (index == 4'd15);

  // State register.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and stream outputs; outputs read zero outside STREAM.
  always_comb begin
    next_state = state;
    out_valid  = 1'b0;
    drain_busy = 1'b0;
    out_data   = '0;
    out_row    = 2'd0;
    out_col    = 2'd0;
    out_last   = 1'b0;
    case (state)
      IDLE: begin
        if (capture) begin
          next_state = STREAM;
        end
      end
      STREAM: begin
        out_valid  = 1'b1;
        drain_busy = 1'b1;
        out_data   = buffer[cur_row][cur_col];
        out_row    = cur_row;
        out_col    = cur_col;
        out_last   = (index == 4'd15);
        if (last_handshake && !capture) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Snapshot buffer, drain index, completion pulse and sticky overrun flag.
  // A capture coinciding with the final handshake reloads for a back-to-back
  // drain; any other capture mid-stream is dropped and flagged.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      for (int r = 0; r < MATRIX_DIM; r++) begin
        for (int c = 0; c < MATRIX_DIM; c++) begin
          buffer[r][c] <= '0;
        end
      end
      index          <= 4'd0;
      drain_complete <= 1'b0;
      overrun_error  <= 1'b0;
    end else begin
      drain_complete <= last_handshake;
      if (state == IDLE) begin
        if (capture) begin
          buffer <= tensor_core_output;
          index  <= 4'd0;
        end
      end else if (last_handshake) begin
        index <= 4'd0;
        if (capture) begin
          buffer <= tensor_core_output;
        end
      end else begin
        if (handshake) begin
          index <= index + 4'd1;
        end
        if (capture) begin
          overrun_error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/tensor_core_result_drain.md
# tensor_core_result_drain

Reads the finished 4x4 result matrix out of the small tensor core and streams it as 16 signed elements over a valid/ready interface. The block snapshots the whole result matrix on the rising edge of the core's done flag, which frees the core for its next load. It then emits elements in fixed order, one per accepted beat, with row/column tags and a last marker. It sits between the tensor core output and the register-file/host write-back path.

## Interface
- ELEM_WIDTH, 4: signed element width; matches the tensor core bus width (`BUS_WIDTH+1).
- MATRIX_DIM, 4: matrix dimension; fixed at 4, not intended to be overridden.
- clock_in  in  1  single clock, all logic on posedge.
- reset_in  in  1  synchronous, active-high reset.
- is_done_with_calculation  in  1  level flag from the tensor core; result valid while high.
- tensor_core_output  in  signed [ELEM_WIDTH-1:0] [4][4]  result matrix from the core.
- out_valid  out  1  element beat available.
- out_ready  in  1  downstream accepts the beat when high with out_valid.
- out_data  out  signed ELEM_WIDTH  element value.
- out_row, out_col  out  2 each  element coordinates.
- out_last  out  1  high on the 16th beat.
- drain_busy  out  1  high while in STREAM.
- drain_complete  out  1  one-cycle pulse after the last beat is accepted.
- overrun_error  out  1  sticky; a new result arrived mid-stream.

## Operation
- Edge detect: done_q <= is_done_with_calculation. capture = is_done_with_calculation & ~done_q. done_q resets to 1, so a level still high after reset is not captured.
- States are IDLE and STREAM.
- IDLE:
  - On capture: copy all 16 elements into the snapshot buffer, set index to 0, and go to STREAM.
  - Otherwise hold.
- STREAM:
  - out_valid is 1. out_data is buffer[index]. out_row and out_col are derived from index. out_last = (index==15).
  - On out_valid & out_ready, index increments.
  - On the last-beat handshake, go to IDLE and pulse drain_complete.
- Stability: while out_valid is high and out_ready is low, out_data, out_row, out_col and out_last hold constant.
- Capture while in STREAM without a last-beat handshake in the same cycle: set overrun_error (sticky). The buffer and index are unchanged and the new result is dropped.
- Capture in the same cycle as the last-beat handshake: reload the buffer, set index to 0, stay in STREAM. drain_complete still pulses and no overrun is flagged (back-to-back results).
- Data is passed through bit-exact with no width change; index is 4 bits and never wraps past 15.
- Reset values: out_valid 0, out_data 0, out_row 0, out_col 0, out_last 0, drain_busy 0, drain_complete 0, overrun_error 0, state IDLE, index 0, buffer all 0.

## Timing
- Capture at posedge N gives out_valid=1 from cycle N+1, with the first beat's data already valid.
- With out_ready held high, beats fall in cycles N+1..N+16, out_last is high in cycle N+16, and drain_complete is high in cycle N+17.
- Throughput is 1 element/cycle. Each cycle of out_ready low adds one cycle.
- Reset asserted mid-stream: at the next edge all outputs go to reset values. The partially sent matrix is abandoned and no drain_complete is issued.

## Configuration
- DRAIN_COLUMN_MAJOR_EN:
  - Defined: column-major order, index→(row=index%4, col=index/4).
  - Undefined: row-major order, row=index/4, col=index%4.
- Handshake, latency and out_last behaviour are identical in both modes.

## Structure
- Package tensor_core_pkg holds:
  - ELEM_WIDTH and MATRIX_DIM constants;
  - typedef elem_t (signed logic [ELEM_WIDTH-1:0]);
  - typedef matrix_t (elem_t [4][4]);
  - the drain_state_t enum {IDLE, STREAM}.
- One natural sub-module is done_edge_detect (registered rising-edge detector with a reset-value parameter). It is instantiated once.

## Test plan
- Row-major drain: load matrix element (r,c) = r*4+c-8 and pulse done with ready high. Expect 16 beats with out_data -8..7 and (row,col) sequence (0,0),(0,1)…(3,3). out_last is high only on beat 16 and drain_complete is high in the next cycle.
- Backpressure: toggle ready 1,0,0,1,… during the drain. Data/row/col stay stable while stalled, the count is still 16 beats, and no element is duplicated or skipped.
- Overrun: raise done again (low, then high) at beat 5. overrun_error becomes 1 and stays 1; the remaining beats carry the original matrix values.
- Back-to-back: create a new rising edge of done in the same cycle as the beat-16 handshake of matrix A. Expect no overrun, drain_complete pulsed, and matrix B's (0,0) presented in the next cycle.
- Reset: hold done high through reset, with reset asserted at beat 7. All outputs read 0 after reset and no capture occurs until done falls and rises again.
- DRAIN_COLUMN_MAJOR_EN build: same matrix as the row-major case. Expected out_data order is -8,-4,0,4,-7,-3,… with (row,col) order (0,0),(1,0),(2,0),(3,0),(0,1)….
